// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: condition-code encodings and the
// condition evaluation helper used when resolving a branch.
package branch_pkg;

   // Condition codes: one "always", five single-flag tests, two "never" codes.
   typedef enum logic [2:0] {
      CC_ALWAYS = 3'b000,
      CC_F5     = 3'b001,
      CC_F4     = 3'b010,
      CC_F3     = 3'b011,
      CC_F2     = 3'b100,
      CC_F1     = 3'b101,
      CC_NEVER  = 3'b110,
      CC_NEVER2 = 3'b111
   } cc_e;

   // Returns 1 when the condition code selects a taken branch for these flags.
   function automatic logic check_cc(input logic [2:0] cc, input logic [5:0] flags);
      logic taken;
      case (cc_e'(cc))
         CC_ALWAYS: taken = 1'b1;
         CC_F5:     taken = flags[5];
         CC_F4:     taken = flags[4];
         CC_F3:     taken = flags[3];
         CC_F2:     taken = flags[2];
         CC_F1:     taken = flags[1];
         CC_NEVER:  taken = 1'b0;
         CC_NEVER2: taken = 1'b0;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack. A push on a full stack overwrites the oldest
// entry while the occupancy count saturates; pops and replaces are ignored on
// an empty stack, and the top reads as zero while empty.
module branch_ras
   import branch_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int RAS_DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              replace_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] top_o,
   output logic              empty_o,
   output logic              full_o
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [DATA_W-1:0] mem_r [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_r;      // next slot to write
   logic [CNT_W-1:0]  cnt_r;      // valid entries, saturating at RAS_DEPTH
   logic [PTR_W-1:0]  top_idx_s;

   assign top_idx_s = ptr_r - PTR_W'(1'b1);
   assign empty_o   = (cnt_r == {CNT_W{1'b0}});
   assign full_o    = (cnt_r == CNT_FULL);

   // Top-of-stack read, forced to zero while the stack holds nothing
   always_comb begin
      top_o = {DATA_W{1'b0}};
      if (empty_o) begin
         top_o = {DATA_W{1'b0}};
      end else begin
         top_o = mem_r[top_idx_s];
      end
   end

   // Stack storage plus write pointer and occupancy bookkeeping
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         ptr_r <= {PTR_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (push_i) begin
         mem_r[ptr_r] <= data_i;
         ptr_r        <= ptr_r + PTR_W'(1'b1);
         if (!full_o) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end
      end else if (pop_i) begin
         if (!empty_o) begin
            ptr_r <= top_idx_s;
            cnt_r <= cnt_r - CNT_W'(1'b1);
         end
      end else if (replace_i) begin
         if (!empty_o) begin
            mem_r[top_idx_s] <= data_i;
         end
      end
   end

endmodule

// File: rtl/branch_unit_ras.sv
// Pipelined branch-resolution unit with return-address stack. One request is
// resolved per accepted beat into a single output register (1-cycle latency).
// Optional feature macro: BRANCH_UNIT_PERF_EN adds taken / not-taken counters.
module branch_unit_ras
   import branch_pkg::*;
#(
   parameter int PC_W      = 16,
   parameter int DATA_W    = 32,
   parameter int FLAG_W    = 6,
   parameter int RAS_DEPTH = 8,
   parameter int LINK_INC  = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [2:0]        cc_i,
   input  logic [FLAG_W-1:0] flags_i,
   input  logic [DATA_W-1:0] src_i,
   input  logic              abs_i,
   input  logic              link_i,
   input  logic              ret_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] dest_addr_o,
   output logic              branch_en_o,
   output logic [DATA_W-1:0] link_addr_o,
   output logic              ras_uflow_o
`ifdef BRANCH_UNIT_PERF_EN
   ,
   output logic [31:0]       perf_taken_o,
   output logic [31:0]       perf_ntaken_o
`endif
);

   logic              accept_s;
   logic              taken_s;
   logic              upd_s;
   logic              uflow_s;
   logic              push_s;
   logic              pop_s;
   logic              replace_s;
   logic              ras_empty_s;
   logic              unused_ras_full_s;
   logic              unused_flags_s;
   logic [DATA_W-1:0] pc_ext_s;
   logic [DATA_W-1:0] target_s;
   logic [DATA_W-1:0] link_addr_s;
   logic [DATA_W-1:0] ras_top_s;

   logic              valid_r;
   logic              branch_en_r;
   logic              uflow_r;
   logic [DATA_W-1:0] dest_r;
   logic [DATA_W-1:0] link_r;

   // Only flags[5:1] participate in conditions; wider flag words are ignored.
   assign unused_flags_s = ^flags_i;

   // Single output register: free when empty or being drained this cycle.
   // Flush wins over a same-cycle request, so such a request is dropped.
   assign ready_o  = !valid_r || ready_i;
   assign accept_s = valid_i && ready_o && !flush_i;

   // Condition evaluation, target selection and stack-operation decode
   always_comb begin
      taken_s     = check_cc(cc_i, flags_i[5:0]);
      pc_ext_s    = {{(DATA_W-PC_W){1'b0}}, pc_i};
      link_addr_s = pc_ext_s + DATA_W'(LINK_INC);
      target_s    = {DATA_W{1'b0}};
      uflow_s     = 1'b0;
      if (ret_i) begin
         // Empty stack reads as zero; flag underflow only if a pop is attempted.
         target_s = ras_top_s;
         uflow_s  = taken_s && ras_empty_s;
      end else if (abs_i) begin
         target_s = src_i;
      end else begin
         target_s = pc_ext_s + src_i;
      end
      upd_s     = accept_s && taken_s;
      push_s    = upd_s && link_i && !ret_i;
      pop_s     = upd_s && ret_i && !link_i;
      replace_s = upd_s && link_i && ret_i;
   end

   branch_ras #(
      .DATA_W    (DATA_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .push_i    (push_s),
      .pop_i     (pop_s),
      .replace_i (replace_s),
      .data_i    (link_addr_s),
      .top_o     (ras_top_s),
      .empty_o   (ras_empty_s),
      .full_o    (unused_ras_full_s)
   );

   // Result register: load on accept, clear on flush or consumption, else hold
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_r     <= 1'b0;
         branch_en_r <= 1'b0;
         uflow_r     <= 1'b0;
         dest_r      <= {DATA_W{1'b0}};
         link_r      <= {DATA_W{1'b0}};
      end else if (flush_i) begin
         valid_r <= 1'b0;
      end else if (accept_s) begin
         valid_r     <= 1'b1;
         branch_en_r <= taken_s;
         uflow_r     <= uflow_s;
         dest_r      <= target_s;
         link_r      <= link_addr_s;
      end else if (ready_i) begin
         valid_r <= 1'b0;
      end
   end

   assign valid_o     = valid_r;
   assign branch_en_o = branch_en_r;
   assign ras_uflow_o = uflow_r;
   assign dest_addr_o = dest_r;
   assign link_addr_o = link_r;

`ifdef BRANCH_UNIT_PERF_EN
   logic [31:0] perf_taken_r;
   logic [31:0] perf_ntaken_r;

   // Count accepted beats by outcome; counters wrap naturally
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_taken_r  <= 32'd0;
         perf_ntaken_r <= 32'd0;
      end else if (accept_s) begin
         if (taken_s) begin
            perf_taken_r <= perf_taken_r + 32'd1;
         end else begin
            perf_ntaken_r <= perf_ntaken_r + 32'd1;
         end
      end
   end

   assign perf_taken_o  = perf_taken_r;
   assign perf_ntaken_o = perf_ntaken_r;
`endif

endmodule
